// File: rtl/wide_add_sequencer_if.sv
// Operand and result handshake bundle for wide_add_sequencer.
// master drives operands and out_ready; slave is the sequencer.
interface wide_add_sequencer_if #(
  parameter int NWORDS = 4
) ();
  localparam int W = 16 * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, a, b,
    output carry_in, sub, out_ready,
    input  in_ready, out_valid, sum,
    input  carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b,
    input  carry_in, sub, out_ready,
    output in_ready, out_valid, sum,
    output carry_out, overflow, busy
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Word-serial wide add/sub using one 16-bit carry-select adder.
// Ports: clk, rst_n (sync, active-low), bus (operands in, result out).
module carry_select_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryIn,
  output logic [15:0] sum,
  output logic        carryOut
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]}
             + {8'd0, carryIn};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = hi0 + 9'd1;

  assign sum[7:0] = lo[7:0];
  assign {carryOut, sum[15:8]} = lo[8] ? hi1 : hi0;
endmodule

module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input logic clk,
  input logic rst_n,
  wide_add_sequencer_if.slave bus
);
  localparam int W  = 16 * NWORDS;
  localparam int KW = $clog2(NWORDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-17:0] res_q;
  logic [W-1:0]  sum_q;
  logic [KW-1:0] k_q;
  logic          c_q;
  logic          co_q;
  logic          ov_q;

  logic [W-1:0] b_eff;
  logic [W-1:0] res_cat;
  logic [15:0]  add_sum;
  logic         add_co;
  logic         accept;
  logic         run;
  logic         last;

  carry_select_add16 u_add (
    .a        (a_q[15:0]),
    .b        (b_q[15:0]),
    .carryIn  (c_q),
    .sum      (add_sum),
    .carryOut (add_co)
  );

  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign accept = (state_q == IDLE) & bus.in_valid;
  assign run    = (state_q == RUN);
  assign last   = run & (k_q == KW'(NWORDS - 1));
  // finished words shift in from the top; after the
  // last word the full result is {add_sum, res_q}
  assign res_cat = {add_sum, res_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)  state_d = RUN;
      RUN:  if (last)          state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      sum_q <= '0;
      k_q   <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= b_eff;
      c_q <= bus.sub | bus.carry_in;
      k_q <= '0;
    end else if (run) begin
      a_q   <= a_q >> 16;
      b_q   <= b_q >> 16;
      res_q <= res_cat[W-1:16];
      c_q   <= add_co;
      k_q   <= k_q + KW'(1);
      if (last) begin
        // a_q/b_q now hold the top word
        sum_q <= res_cat;
        co_q  <= add_co;
        ov_q  <= (a_q[15] == b_q[15])
               & (add_sum[15] != a_q[15]);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
endmodule
